// File: rtl/ew_fsm_multi_monitor_pkg.sv
// ew_mon_pkg: shared types and helpers for the EW channel FSM monitor.
// Channel state encoding: IDLE=0 .. RECOVERY=6, code 7 is undefined.
// Optional feature macro used by the monitor: EW_DWELL_WDOG_EN.
package ew_mon_pkg;

   typedef enum logic [2:0] {
      ST_IDLE             = 3'd0,
      ST_MONITOR          = 3'd1,
      ST_JAMMED           = 3'd2,
      ST_SPOOF_DETECTED   = 3'd3,
      ST_ENTROPY_ANALYZED = 3'd4,
      ST_COUNTER_MEASURE  = 3'd5,
      ST_RECOVERY         = 3'd6,
      ST_UNDEFINED        = 3'd7
   } fsm_state_t;

   typedef enum logic [1:0] {
      ERR_NONE       = 2'd0,
      ERR_INVALID    = 2'd1,
      ERR_TRANSITION = 2'd2,
      ERR_DWELL      = 2'd3
   } err_code_t;

   typedef enum logic {
      CH_UNARMED = 1'b0,
      CH_ARMED   = 1'b1
   } ch_state_t;

   // Transition table of the monitored EW controller FSM.
   function automatic logic is_legal_transition(input logic [2:0] from, input logic [2:0] to);
      logic ok;
      case (fsm_state_t'(from))
         ST_IDLE:             ok = (to == ST_MONITOR);
         ST_MONITOR:          ok = (to == ST_MONITOR) || (to == ST_IDLE) || (to == ST_JAMMED) ||
                                   (to == ST_SPOOF_DETECTED) || (to == ST_ENTROPY_ANALYZED);
         ST_JAMMED:           ok = (to == ST_JAMMED) || (to == ST_COUNTER_MEASURE);
         ST_SPOOF_DETECTED:   ok = (to == ST_SPOOF_DETECTED) || (to == ST_COUNTER_MEASURE);
         ST_ENTROPY_ANALYZED: ok = (to == ST_ENTROPY_ANALYZED) || (to == ST_MONITOR) ||
                                   (to == ST_COUNTER_MEASURE);
         ST_COUNTER_MEASURE:  ok = (to == ST_COUNTER_MEASURE) || (to == ST_RECOVERY);
         ST_RECOVERY:         ok = (to == ST_RECOVERY) || (to == ST_MONITOR) || (to == ST_IDLE);
         default:             ok = 1'b0;
      endcase
      return ok;
   endfunction

   // States whose residence time is watched by the dwell watchdog.
   function automatic logic is_dwell_state(input logic [2:0] s);
      logic ok;
      case (fsm_state_t'(s))
         ST_IDLE, ST_MONITOR, ST_UNDEFINED: ok = 1'b0;
         default:                           ok = 1'b1;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/ew_fsm_multi_monitor_if.sv
// Sample/status bundle between the EW controller side and the FSM monitor.
interface ew_fsm_multi_monitor_if #(
   parameter int FSM_BITS = 3,
   parameter int NUM_CH   = 4,
   parameter int CNT_W    = 16
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [NUM_CH*FSM_BITS-1:0] fsm_state;
   logic [NUM_CH-1:0]          state_vld;
   logic                       clear;
   logic [NUM_CH-1:0]          err_invalid;
   logic [NUM_CH-1:0]          err_transition;
   logic [NUM_CH-1:0]          err_dwell;
   logic [CNT_W-1:0]           viol_count;
   logic                       first_err_vld;
   logic [CH_W-1:0]            first_err_ch;
   logic [1:0]                 first_err_code;
   logic [FSM_BITS-1:0]        first_err_from;
   logic [FSM_BITS-1:0]        first_err_to;
   logic                       irq;

   modport master (
      output fsm_state, state_vld, clear,
      input  err_invalid, err_transition, err_dwell, viol_count,
             first_err_vld, first_err_ch, first_err_code,
             first_err_from, first_err_to, irq
   );

   modport slave (
      input  fsm_state, state_vld, clear,
      output err_invalid, err_transition, err_dwell, viol_count,
             first_err_vld, first_err_ch, first_err_code,
             first_err_from, first_err_to, irq
   );
endinterface

// File: rtl/ew_fsm_multi_monitor_chan_checker.sv
// ew_fsm_chan_checker: one monitored channel. Owns the arm FSM, the previous
// state, the optional dwell counter (EW_DWELL_WDOG_EN) and registered
// one-cycle error pulses with the from/to states that produced them.
module ew_fsm_chan_checker
   import ew_mon_pkg::*;
#(
   parameter int FSM_BITS  = 3,
   parameter int DWELL_MAX = 1024
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                vld,
   input  logic [FSM_BITS-1:0] cur,
   output logic                err_inv,
   output logic                err_trn,
   output logic                err_dwl,
   output logic [FSM_BITS-1:0] err_from,
   output logic [FSM_BITS-1:0] err_to
);

   ch_state_t           arm_r, arm_nxt_s;
   logic [FSM_BITS-1:0] prev_r, prev_nxt_s;
   logic                cur_ok_s;
   logic                inv_s, trn_s, dwl_s;

   assign cur_ok_s = (cur < FSM_BITS'(7));

   // Arm state register; a reset disarms the channel.
   always_ff @(posedge clk) begin
      if (rst) begin
         arm_r <= CH_UNARMED;
      end else begin
         arm_r <= arm_nxt_s;
      end
   end

   // Arm next state: any legal sample arms, an undefined code disarms.
   always_comb begin
      arm_nxt_s = arm_r;
      case (arm_r)
         CH_UNARMED, CH_ARMED: begin
            if (vld) begin
               if (cur_ok_s) arm_nxt_s = CH_ARMED;
               else          arm_nxt_s = CH_UNARMED;
            end else begin
               arm_nxt_s = arm_r;
            end
         end
         default: arm_nxt_s = CH_UNARMED;
      endcase
   end

   // Per-sample checks: undefined code, then table check once armed.
   always_comb begin
      inv_s      = 1'b0;
      trn_s      = 1'b0;
      prev_nxt_s = prev_r;
      if (vld) begin
         if (!cur_ok_s) begin
            inv_s = 1'b1;
         end else begin
            prev_nxt_s = cur;
            if (arm_r == CH_ARMED) trn_s = !is_legal_transition(prev_r[2:0], cur[2:0]);
            else                   trn_s = 1'b0;
         end
      end else begin
         prev_nxt_s = prev_r;
      end
   end

`ifdef EW_DWELL_WDOG_EN
   // One extra count value marks "already reported" so the error fires once.
   localparam int DW_W = $clog2(DWELL_MAX + 2);
   logic [DW_W-1:0] dwell_r, dwell_nxt_s;

   // Dwell counter next value and the single dwell-exceeded pulse.
   always_comb begin
      dwell_nxt_s = dwell_r;
      dwl_s       = 1'b0;
      if (vld) begin
         if (!cur_ok_s) begin
            dwell_nxt_s = '0;
         end else if ((arm_r == CH_ARMED) && (cur == prev_r)) begin
            if (!is_dwell_state(cur[2:0])) begin
               dwell_nxt_s = '0;
            end else if (dwell_r == DW_W'(DWELL_MAX)) begin
               dwl_s       = 1'b1;
               dwell_nxt_s = DW_W'(DWELL_MAX + 1);
            end else if (dwell_r == DW_W'(DWELL_MAX + 1)) begin
               dwell_nxt_s = dwell_r;
            end else begin
               dwell_nxt_s = dwell_r + DW_W'(1);
            end
         end else begin
            dwell_nxt_s = is_dwell_state(cur[2:0]) ? DW_W'(1) : DW_W'(0);
         end
      end else begin
         dwell_nxt_s = dwell_r;
      end
   end

   // Dwell counter register.
   always_ff @(posedge clk) begin
      if (rst) dwell_r <= '0;
      else     dwell_r <= dwell_nxt_s;
   end
`else
   assign dwl_s = 1'b0;
`endif

   // Previous state and registered error pulses toward the aggregator.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_r   <= '0;
         err_inv  <= 1'b0;
         err_trn  <= 1'b0;
         err_dwl  <= 1'b0;
         err_from <= '0;
         err_to   <= '0;
      end else begin
         prev_r   <= prev_nxt_s;
         err_inv  <= inv_s;
         err_trn  <= trn_s;
         err_dwl  <= dwl_s;
         err_from <= prev_r;
         err_to   <= cur;
      end
   end

endmodule

// File: rtl/ew_fsm_multi_monitor.sv
// ew_fsm_multi_monitor: in-silicon legality monitor for NUM_CH EW channel FSMs.
// Aggregates per-channel error pulses into sticky flags, a saturating
// violation count and a first-error capture. Dwell watchdog is built only
// when EW_DWELL_WDOG_EN is defined.
module ew_fsm_multi_monitor
   import ew_mon_pkg::*;
#(
   parameter int FSM_BITS  = 3,
   parameter int NUM_CH    = 4,
   parameter int CNT_W     = 16,
   parameter int DWELL_MAX = 1024
) (
   input logic                  clk,
   input logic                  rst,
   ew_fsm_multi_monitor_if.slave mon
);

   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int EV_W  = $clog2(3 * NUM_CH + 1);
   localparam int SUM_W = ((CNT_W > EV_W) ? CNT_W : EV_W) + 1;

   logic [NUM_CH-1:0]   inv_s, trn_s, dwl_s;
   logic [FSM_BITS-1:0] from_s [NUM_CH];
   logic [FSM_BITS-1:0] to_s   [NUM_CH];

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      ew_fsm_chan_checker #(
         .FSM_BITS  (FSM_BITS),
         .DWELL_MAX (DWELL_MAX)
      ) u_chk (
         .clk      (clk),
         .rst      (rst),
         .vld      (mon.state_vld[g]),
         .cur      (mon.fsm_state[g*FSM_BITS +: FSM_BITS]),
         .err_inv  (inv_s[g]),
         .err_trn  (trn_s[g]),
         .err_dwl  (dwl_s[g]),
         .err_from (from_s[g]),
         .err_to   (to_s[g])
      );
   end

   logic [NUM_CH-1:0]   inv_r, trn_r;
   logic [CNT_W-1:0]    cnt_r, cnt_base_s, cnt_nxt_s;
   logic [SUM_W-1:0]    cnt_sum_s;
   logic [EV_W-1:0]     ev_cnt_s;
   logic                hit_s;
   logic [CH_W-1:0]     hit_ch_s;
   err_code_t           hit_code_s;
   logic [FSM_BITS-1:0] hit_from_s, hit_to_s;
   logic                cap_vld_r, cap_vld_nxt_s, irq_r;
   logic [CH_W-1:0]     cap_ch_r, cap_ch_nxt_s;
   logic [1:0]          cap_code_r, cap_code_nxt_s;
   logic [FSM_BITS-1:0] cap_from_r, cap_from_nxt_s, cap_to_r, cap_to_nxt_s;

   // Number of error events of all kinds across all channels this cycle.
   always_comb begin
      ev_cnt_s = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         ev_cnt_s = ev_cnt_s + EV_W'(inv_s[i]) + EV_W'(trn_s[i]) + EV_W'(dwl_s[i]);
      end
   end

   // Saturating violation count; clear zeroes first, then this cycle's events add.
   always_comb begin
      if (mon.clear) cnt_base_s = '0;
      else           cnt_base_s = cnt_r;
      cnt_sum_s = SUM_W'(cnt_base_s) + SUM_W'(ev_cnt_s);
      if (cnt_sum_s > SUM_W'({CNT_W{1'b1}})) cnt_nxt_s = '1;
      else                                   cnt_nxt_s = cnt_sum_s[CNT_W-1:0];
   end

   // Lowest erroring channel wins; within a channel invalid > transition > dwell.
   always_comb begin
      hit_s      = 1'b0;
      hit_ch_s   = '0;
      hit_code_s = ERR_NONE;
      hit_from_s = '0;
      hit_to_s   = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (inv_s[i] || trn_s[i] || dwl_s[i]) begin
            hit_s      = 1'b1;
            hit_ch_s   = CH_W'(i);
            hit_from_s = from_s[i];
            hit_to_s   = to_s[i];
            if (inv_s[i])      hit_code_s = ERR_INVALID;
            else if (trn_s[i]) hit_code_s = ERR_TRANSITION;
            else               hit_code_s = ERR_DWELL;
         end else begin
            hit_s = hit_s;
         end
      end
   end

   // First-error capture: loads only into an empty record (after clear).
   always_comb begin
      cap_vld_nxt_s  = cap_vld_r;
      cap_ch_nxt_s   = cap_ch_r;
      cap_code_nxt_s = cap_code_r;
      cap_from_nxt_s = cap_from_r;
      cap_to_nxt_s   = cap_to_r;
      if (hit_s && (mon.clear || !cap_vld_r)) begin
         cap_vld_nxt_s  = 1'b1;
         cap_ch_nxt_s   = hit_ch_s;
         cap_code_nxt_s = hit_code_s;
         cap_from_nxt_s = hit_from_s;
         cap_to_nxt_s   = hit_to_s;
      end else if (mon.clear) begin
         cap_vld_nxt_s  = 1'b0;
         cap_ch_nxt_s   = '0;
         cap_code_nxt_s = 2'd0;
         cap_from_nxt_s = '0;
         cap_to_nxt_s   = '0;
      end else begin
         cap_vld_nxt_s = cap_vld_r;
      end
   end

   // Status registers: sticky flags, count, capture and irq.
   always_ff @(posedge clk) begin
      if (rst) begin
         inv_r      <= '0;
         trn_r      <= '0;
         cnt_r      <= '0;
         cap_vld_r  <= 1'b0;
         cap_ch_r   <= '0;
         cap_code_r <= 2'd0;
         cap_from_r <= '0;
         cap_to_r   <= '0;
         irq_r      <= 1'b0;
      end else begin
         inv_r      <= (mon.clear ? '0 : inv_r) | inv_s;
         trn_r      <= (mon.clear ? '0 : trn_r) | trn_s;
         cnt_r      <= cnt_nxt_s;
         cap_vld_r  <= cap_vld_nxt_s;
         cap_ch_r   <= cap_ch_nxt_s;
         cap_code_r <= cap_code_nxt_s;
         cap_from_r <= cap_from_nxt_s;
         cap_to_r   <= cap_to_nxt_s;
         irq_r      <= cap_vld_nxt_s;
      end
   end

`ifdef EW_DWELL_WDOG_EN
   logic [NUM_CH-1:0] dwl_r;

   // Sticky dwell flags.
   always_ff @(posedge clk) begin
      if (rst) dwl_r <= '0;
      else     dwl_r <= (mon.clear ? '0 : dwl_r) | dwl_s;
   end

   assign mon.err_dwell = dwl_r;
`else
   assign mon.err_dwell = '0;
`endif

   assign mon.err_invalid    = inv_r;
   assign mon.err_transition = trn_r;
   assign mon.viol_count     = cnt_r;
   assign mon.first_err_vld  = cap_vld_r;
   assign mon.first_err_ch   = cap_ch_r;
   assign mon.first_err_code = cap_code_r;
   assign mon.first_err_from = cap_from_r;
   assign mon.first_err_to   = cap_to_r;
   assign mon.irq            = irq_r;

endmodule

// File: tb/tb_ew_fsm_multi_monitor.sv
// Bench for ew_fsm_multi_monitor: directed scenarios plus random stimulus,
// compared every cycle against a behavioural model of the monitor rules.
module tb_ew_fsm_multi_monitor;

   localparam int NCH = 4;
   localparam int FB  = 3;
   localparam int CW  = 4;
   localparam int DM  = 4;
   localparam int SAT = (1 << CW) - 1;
`ifdef EW_DWELL_WDOG_EN
   localparam bit DWELL_ON = 1'b1;
`else
   localparam bit DWELL_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ew_fsm_multi_monitor_if #(.FSM_BITS(FB), .NUM_CH(NCH), .CNT_W(CW)) bus ();

   ew_fsm_multi_monitor #(
      .FSM_BITS(FB), .NUM_CH(NCH), .CNT_W(CW), .DWELL_MAX(DM)
   ) dut (
      .clk (clk),
      .rst (rst),
      .mon (bus)
   );

   int n_total = 0;
   int n_pass  = 0;

   // allowed successors: bit 'to' of succ[from]
   bit [7:0] succ [8];

   // model state
   bit       m_armed [NCH];
   int       m_prev  [NCH];
   int       m_run   [NCH];
   bit       m_fired [NCH];
   bit       p_inv [NCH], p_trn [NCH], p_dwl [NCH];
   int       p_from [NCH], p_to [NCH];
   bit [NCH-1:0] m_inv, m_trn, m_dwl;
   int       m_cnt;
   bit       m_cap_vld;
   int       m_cap_ch, m_cap_code, m_cap_from, m_cap_to;
   int       last_drv [NCH];

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      else n_pass++;
   endtask

   function automatic bit counted(input int s);
      return (s >= 2) && (s <= 6);
   endfunction

   task automatic model_edge(input bit [NCH-1:0] vld, input bit [NCH*FB-1:0] st,
                             input bit clr, input bit r);
      int n;
      int s;
      if (r) begin
         for (int c = 0; c < NCH; c++) begin
            m_armed[c] = 0; m_prev[c] = 0; m_run[c] = 0; m_fired[c] = 0;
            p_inv[c] = 0; p_trn[c] = 0; p_dwl[c] = 0; p_from[c] = 0; p_to[c] = 0;
         end
         m_inv = '0; m_trn = '0; m_dwl = '0; m_cnt = 0;
         m_cap_vld = 0; m_cap_ch = 0; m_cap_code = 0; m_cap_from = 0; m_cap_to = 0;
         return;
      end
      if (clr) begin
         m_inv = '0; m_trn = '0; m_dwl = '0; m_cnt = 0;
         m_cap_vld = 0; m_cap_ch = 0; m_cap_code = 0; m_cap_from = 0; m_cap_to = 0;
      end
      // events found one cycle earlier become visible now
      for (int c = 0; c < NCH; c++) begin
         n = int'(p_inv[c]) + int'(p_trn[c]) + int'(p_dwl[c]);
         m_inv[c] = m_inv[c] | p_inv[c];
         m_trn[c] = m_trn[c] | p_trn[c];
         m_dwl[c] = m_dwl[c] | p_dwl[c];
         m_cnt = (m_cnt + n > SAT) ? SAT : m_cnt + n;
         if (!m_cap_vld && n > 0) begin
            m_cap_vld  = 1;
            m_cap_ch   = c;
            m_cap_code = p_inv[c] ? 1 : (p_trn[c] ? 2 : 3);
            m_cap_from = p_from[c];
            m_cap_to   = p_to[c];
         end
      end
      // evaluate this cycle's samples
      for (int c = 0; c < NCH; c++) begin
         p_inv[c] = 0; p_trn[c] = 0; p_dwl[c] = 0;
         if (vld[c]) begin
            s = int'(st[c*FB +: FB]);
            p_from[c] = m_prev[c];
            p_to[c]   = s;
            if (s == 7) begin
               p_inv[c] = 1; m_armed[c] = 0; m_run[c] = 0; m_fired[c] = 0;
            end else if (m_armed[c]) begin
               if (!succ[m_prev[c]][s]) p_trn[c] = 1;
               if (s == m_prev[c]) begin
                  if (counted(s)) m_run[c]++;
                  if (DWELL_ON && m_run[c] == DM + 1 && !m_fired[c]) begin
                     p_dwl[c] = 1; m_fired[c] = 1;
                  end
               end else begin
                  m_run[c] = counted(s) ? 1 : 0; m_fired[c] = 0;
               end
               m_prev[c] = s;
            end else begin
               m_armed[c] = 1; m_run[c] = counted(s) ? 1 : 0; m_fired[c] = 0;
               m_prev[c] = s;
            end
         end
      end
   endtask

   task automatic compare_all();
      check_val("err_invalid",    bus.err_invalid,    m_inv);
      check_val("err_transition", bus.err_transition, m_trn);
      check_val("err_dwell",      bus.err_dwell,      m_dwl);
      check_val("viol_count",     bus.viol_count,     m_cnt);
      check_val("first_err_vld",  bus.first_err_vld,  m_cap_vld);
      check_val("first_err_ch",   bus.first_err_ch,   m_cap_ch);
      check_val("first_err_code", bus.first_err_code, m_cap_code);
      check_val("first_err_from", bus.first_err_from, m_cap_from);
      check_val("first_err_to",   bus.first_err_to,   m_cap_to);
      check_val("irq",            bus.irq,            m_cap_vld);
   endtask

   task automatic cycle(input bit [NCH-1:0] vld, input bit [NCH*FB-1:0] st,
                        input bit clr, input bit r);
      bus.state_vld = vld;
      bus.fsm_state = st;
      bus.clear     = clr;
      rst           = r;
      @(posedge clk);
      #1;
      model_edge(vld, st, clr, r);
      compare_all();
   endtask

   function automatic bit [NCH*FB-1:0] pk(input int s0, input int s1, input int s2, input int s3);
      bit [NCH*FB-1:0] v;
      v = {FB'(s3), FB'(s2), FB'(s1), FB'(s0)};
      return v;
   endfunction

   task automatic idle();
      cycle(4'b0000, '0, 1'b0, 1'b0);
   endtask

   initial begin
      int seq0 [6];
      bit [NCH-1:0] vld;
      bit [NCH*FB-1:0] st;
      int opts [8];
      int nopt;
      int pick;

      succ[0] = 8'b0000_0010;
      succ[1] = 8'b0001_1111;
      succ[2] = 8'b0010_0100;
      succ[3] = 8'b0010_1000;
      succ[4] = 8'b0011_0010;
      succ[5] = 8'b0110_0000;
      succ[6] = 8'b0100_0011;
      succ[7] = 8'b0000_0000;
      for (int c = 0; c < NCH; c++) last_drv[c] = 0;

      bus.state_vld = '0;
      bus.fsm_state = '0;
      bus.clear     = 1'b0;

      // reset
      cycle(4'b0000, '0, 1'b0, 1'b1);
      cycle(4'b0000, '0, 1'b0, 1'b1);
      check_val("reset_count", bus.viol_count, 0);
      check_val("reset_irq", bus.irq, 0);

      // 1: legal walk on ch0
      seq0 = '{0, 1, 2, 5, 6, 1};
      foreach (seq0[i]) cycle(4'b0001, pk(seq0[i], 0, 0, 0), 1'b0, 1'b0);
      idle();
      check_val("t1_count", bus.viol_count, 0);
      check_val("t1_irq", bus.irq, 0);
      check_val("t1_trn", bus.err_transition, 0);

      // 2: ch1 JAMMED -> RECOVERY
      cycle(4'b0010, pk(0, 2, 0, 0), 1'b0, 1'b0);
      cycle(4'b0010, pk(0, 6, 0, 0), 1'b0, 1'b0);
      idle();
      check_val("t2_trn", bus.err_transition, 4'b0010);
      check_val("t2_count", bus.viol_count, 1);
      check_val("t2_ch", bus.first_err_ch, 1);
      check_val("t2_code", bus.first_err_code, 2);
      check_val("t2_from", bus.first_err_from, 2);
      check_val("t2_to", bus.first_err_to, 6);

      // 3: simultaneous invalid on ch2 and illegal transition on ch3
      cycle(4'b0000, '0, 1'b1, 1'b0);
      cycle(4'b1100, pk(0, 0, 1, 0), 1'b0, 1'b0);
      cycle(4'b1100, pk(0, 0, 7, 2), 1'b0, 1'b0);
      idle();
      check_val("t3_count", bus.viol_count, 2);
      check_val("t3_ch", bus.first_err_ch, 2);
      check_val("t3_code", bus.first_err_code, 1);
      check_val("t3_inv", bus.err_invalid, 4'b0100);
      check_val("t3_trn", bus.err_transition, 4'b1000);
      cycle(4'b0100, pk(0, 0, 1, 0), 1'b0, 1'b0);
      idle();
      check_val("t3_rearm_count", bus.viol_count, 2);

      // 4: saturation
      repeat (20) cycle(4'b0001, pk(7, 0, 0, 0), 1'b0, 1'b0);
      idle();
      check_val("t4_sat", bus.viol_count, 15);

      // 5: clear in the same cycle as an illegal transition
      cycle(4'b0001, pk(0, 0, 0, 0), 1'b0, 1'b0);
      idle();
      cycle(4'b0001, pk(2, 0, 0, 0), 1'b1, 1'b0);
      idle();
      check_val("t5_count", bus.viol_count, 1);
      check_val("t5_ch", bus.first_err_ch, 0);
      check_val("t5_code", bus.first_err_code, 2);
      check_val("t5_from", bus.first_err_from, 0);
      check_val("t5_to", bus.first_err_to, 2);
      check_val("t5_inv", bus.err_invalid, 0);

`ifdef EW_DWELL_WDOG_EN
      // 6: dwell watchdog
      cycle(4'b0000, '0, 1'b0, 1'b1);
      cycle(4'b0001, pk(0, 0, 0, 0), 1'b0, 1'b0);
      cycle(4'b0001, pk(1, 0, 0, 0), 1'b0, 1'b0);
      repeat (6) cycle(4'b0001, pk(2, 0, 0, 0), 1'b0, 1'b0);
      idle();
      check_val("t6_dwell", bus.err_dwell, 4'b0001);
      check_val("t6_count", bus.viol_count, 1);
      check_val("t6_code", bus.first_err_code, 3);
`endif

      // random phase
      for (int c = 0; c < NCH; c++) last_drv[c] = 0;
      for (int k = 0; k < 600; k++) begin
         for (int c = 0; c < NCH; c++) begin
            vld[c] = ($urandom_range(0, 9) < 6);
            pick = $urandom_range(0, 9);
            if (pick < 3 && last_drv[c] != 7) begin
               st[c*FB +: FB] = FB'(last_drv[c]);
            end else if (pick < 8) begin
               nopt = 0;
               for (int t = 0; t < 8; t++) if (succ[last_drv[c]][t]) begin opts[nopt] = t; nopt++; end
               if (nopt == 0) st[c*FB +: FB] = FB'($urandom_range(0, 6));
               else           st[c*FB +: FB] = FB'(opts[$urandom_range(0, nopt - 1)]);
            end else begin
               st[c*FB +: FB] = FB'($urandom_range(0, 7));
            end
            if (vld[c]) last_drv[c] = int'(st[c*FB +: FB]);
         end
         cycle(vld, st, ($urandom_range(0, 15) == 0), ($urandom_range(0, 199) == 0));
      end
      idle();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
